// File: rtl/sys_pll_reset_seq.sv
// Reset/lock sequencer for the system PLL: pulses PLL reset, qualifies lock,
// releases sys_ready, and recovers from lock loss or lock that never arrives.
module sys_pll_reset_seq #(
  parameter int unsigned RST_HOLD_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input  logic       refclk_i,
  input  logic       rst_i,
  input  logic       pll_locked_i,
  input  logic       force_relock_i,
  output logic       pll_rst_o,
  output logic       sys_ready_o,
  output logic [7:0] relock_count_o,
  output logic       lock_timeout_o,
  output logic [1:0] state_o
);

  // state     | meaning
  // S_HOLD    | PLL reset asserted for RST_HOLD_CYCLES
  // S_WAIT    | waiting for synced lock; timeout running
  // S_STABLE  | counting consecutive lock-high cycles; timeout running
  // S_RUN     | lock qualified, sys_ready high
  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_WAIT   = 2'd1,
    S_STABLE = 2'd2,
    S_RUN    = 2'd3
  } state_t;

  localparam int HW = $clog2(RST_HOLD_CYCLES + 1);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES - 1);
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk;

  state_t        state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [SW-1:0] stab_q, stab_d;
  logic [TW-1:0] tout_q, tout_d;
  logic [7:0]    relock_q, relock_d;
  logic          timeout_q, timeout_d;
  logic          pll_rst_q, sys_ready_q;

  always_ff @(posedge refclk_i) begin
    if (rst_i) sync_q <= '0;
    else       sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked_i};
  end

  assign lk = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    stab_d    = stab_q;
    tout_d    = tout_q;
    relock_d  = relock_q;
    timeout_d = timeout_q;
    if (force_relock_i) begin
      state_d = S_HOLD;
      hold_d  = '0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (hold_q == HOLD_LAST) begin
            state_d = S_WAIT;
            tout_d  = '0;
          end else begin
            hold_d = hold_q + HW'(1);
          end
        end
        S_WAIT: begin
          if (tout_q == TOUT_LAST) begin
            state_d   = S_HOLD;
            hold_d    = '0;
            timeout_d = 1'b1;
          end else begin
            tout_d = tout_q + TW'(1);
            if (lk) begin
              state_d = S_STABLE;
              stab_d  = '0;
            end
          end
        end
        S_STABLE: begin
          // timeout keeps running across STABLE->WAIT bounces
          if (tout_q == TOUT_LAST) begin
            state_d   = S_HOLD;
            hold_d    = '0;
            timeout_d = 1'b1;
          end else begin
            tout_d = tout_q + TW'(1);
            if (!lk) begin
              state_d = S_WAIT;
              stab_d  = '0;
            end else if (stab_q == STAB_LAST) begin
              state_d = S_RUN;
            end else begin
              stab_d = stab_q + SW'(1);
            end
          end
        end
        S_RUN: begin
          if (!lk) begin
            state_d = S_HOLD;
            hold_d  = '0;
            if (relock_q != 8'hFF) relock_d = relock_q + 8'd1;
          end
        end
        default: state_d = S_HOLD;
      endcase
    end
  end

  always_ff @(posedge refclk_i) begin
    if (rst_i) begin
      state_q     <= S_HOLD;
      hold_q      <= '0;
      stab_q      <= '0;
      tout_q      <= '0;
      relock_q    <= '0;
      timeout_q   <= 1'b0;
      pll_rst_q   <= 1'b1;
      sys_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      stab_q      <= stab_d;
      tout_q      <= tout_d;
      relock_q    <= relock_d;
      timeout_q   <= timeout_d;
      pll_rst_q   <= (state_d == S_HOLD);
      sys_ready_q <= (state_d == S_RUN);
    end
  end

  assign pll_rst_o      = pll_rst_q;
  assign sys_ready_o    = sys_ready_q;
  assign relock_count_o = relock_q;
  assign lock_timeout_o = timeout_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_sys_pll_reset_seq.sv
// Bench for sys_pll_reset_seq: directed scenarios plus random stimulus, every
// cycle compared against a phase/elapsed-time model of the sequencer.
module tb_sys_pll_reset_seq;

  localparam int P_HOLD = 4;
  localparam int P_STAB = 8;
  localparam int P_TOUT = 32;
  localparam int P_SYNC = 2;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst, sys_ready, lock_timeout;
  logic [7:0] relock_count;
  logic [1:0] state;

  int n_cmp = 0;
  int n_bad = 0;

  // model: phase 0=HOLD 1=WAIT 2=STABLE 3=RUN, tracked by elapsed cycle counts
  int m_phase = 0;
  int m_in_hold = 0;
  int m_since_wait = 0;
  int m_highs = 0;
  int m_relocks = 0;
  int m_timed_out = 0;
  int lk_hist[P_SYNC];

  sys_pll_reset_seq #(
    .RST_HOLD_CYCLES    (P_HOLD),
    .LOCK_STABLE_CYCLES (P_STAB),
    .LOCK_TIMEOUT_CYCLES(P_TOUT),
    .SYNC_STAGES        (P_SYNC)
  ) dut (
    .refclk_i      (refclk),
    .rst_i         (rst),
    .pll_locked_i  (pll_locked),
    .force_relock_i(force_relock),
    .pll_rst_o     (pll_rst),
    .sys_ready_o   (sys_ready),
    .relock_count_o(relock_count),
    .lock_timeout_o(lock_timeout),
    .state_o       (state)
  );

  always #5 refclk = ~refclk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int lk;
    if (rst) begin
      foreach (lk_hist[i]) lk_hist[i] = 0;
      m_phase = 0; m_in_hold = 0; m_since_wait = 0; m_highs = 0;
      m_relocks = 0; m_timed_out = 0;
      return;
    end
    // lock seen by the sequencer is the input from P_SYNC edges earlier
    lk = lk_hist[P_SYNC-1];
    for (int i = P_SYNC - 1; i > 0; i--) lk_hist[i] = lk_hist[i-1];
    lk_hist[0] = int'(pll_locked);
    if (force_relock) begin
      m_phase = 0; m_in_hold = 0;
    end else if (m_phase == 0) begin
      m_in_hold++;
      if (m_in_hold == P_HOLD) begin m_phase = 1; m_since_wait = 0; end
    end else if (m_phase == 1 || m_phase == 2) begin
      m_since_wait++;
      if (m_since_wait == P_TOUT) begin
        m_phase = 0; m_in_hold = 0; m_timed_out = 1;
      end else if (m_phase == 1) begin
        if (lk != 0) begin m_phase = 2; m_highs = 0; end
      end else if (lk == 0) begin
        m_phase = 1;
      end else begin
        m_highs++;
        if (m_highs == P_STAB) m_phase = 3;
      end
    end else if (lk == 0) begin
      m_phase = 0; m_in_hold = 0;
      if (m_relocks < 255) m_relocks++;
    end
  endtask

  task automatic cyc();
    @(posedge refclk);
    model_step();
    #1;
    check_eq("state", state, m_phase);
    check_eq("pll_rst", pll_rst, (m_phase == 0));
    check_eq("sys_ready", sys_ready, (m_phase == 3));
    check_eq("relock_count", relock_count, m_relocks);
    check_eq("lock_timeout", lock_timeout, m_timed_out);
  endtask

  task automatic run_until_state(input string tag, input logic [1:0] s, input int budget, output int n);
    n = 0;
    while (state !== s && n < budget) begin cyc(); n++; end
    check_eq(tag, state, s);
  endtask

  initial begin
    int n;
    repeat (3) cyc();
    check_eq("rst_state", state, 0);
    check_eq("rst_pll_rst", pll_rst, 1);
    check_eq("rst_sys_ready", sys_ready, 0);
    check_eq("rst_relock", relock_count, 0);
    check_eq("rst_timeout", lock_timeout, 0);

    // lock present from the start
    pll_locked = 1'b1;
    cyc();
    rst = 1'b0;
    n = 0;
    while (pll_rst && n < 50) begin cyc(); n++; end
    check_eq("hold_len", n, P_HOLD);
    n = 0;
    while (!sys_ready && n < 100) begin cyc(); n++; end
    check_eq("ready_after_wait", n, 1 + P_STAB);
    check_eq("ready_relock", relock_count, 0);

    // lock loss in RUN
    pll_locked = 1'b0;
    n = 0;
    while (sys_ready && n < 20) begin cyc(); n++; end
    check_eq("drop_latency", n, P_SYNC + 1);
    check_eq("drop_pll_rst", pll_rst, 1);
    check_eq("drop_relock", relock_count, 1);

    // rising-lock latency from WAIT
    run_until_state("reach_wait", 2'd1, 20, n);
    pll_locked = 1'b1;
    n = 0;
    while (!sys_ready && n < 100) begin cyc(); n++; end
    check_eq("rise_latency", n, P_SYNC + 1 + P_STAB);

    // force in RUN with lock held
    force_relock = 1'b1;
    cyc();
    force_relock = 1'b0;
    check_eq("force_state", state, 0);
    n = 0;
    while (pll_rst && n < 50) begin cyc(); n++; end
    check_eq("force_hold_len", n, P_HOLD);
    check_eq("force_relock_cnt", relock_count, 1);

    // one-cycle glitch during STABLE
    run_until_state("glitch_stable", 2'd2, 20, n);
    repeat (3) cyc();
    pll_locked = 1'b0;
    cyc();
    pll_locked = 1'b1;
    run_until_state("glitch_back_wait", 2'd1, 10, n);
    run_until_state("glitch_restable", 2'd2, 10, n);
    run_until_state("glitch_run", 2'd3, 50, n);
    check_eq("glitch_full_count", n, P_STAB);
    check_eq("glitch_no_timeout", lock_timeout, 0);

    // force coincident with lk drop reaching the FSM
    pll_locked = 1'b0;
    cyc(); cyc();
    force_relock = 1'b1;
    cyc();
    force_relock = 1'b0;
    check_eq("coinc_state", state, 0);
    check_eq("coinc_relock", relock_count, 1);

    // lock never arrives
    run_until_state("to_wait", 2'd1, 20, n);
    n = 0;
    while (state != 2'd0 && n < 100) begin cyc(); n++; end
    check_eq("timeout_len", n, P_TOUT);
    check_eq("timeout_flag", lock_timeout, 1);
    pll_locked = 1'b1;
    run_until_state("to_recover", 2'd3, 200, n);
    check_eq("timeout_sticky", lock_timeout, 1);

    // relock saturation
    for (int k = 0; k < 300; k++) begin
      pll_locked = 1'b0;
      run_until_state("relock_hold", 2'd0, 20, n);
      pll_locked = 1'b1;
      run_until_state("relock_run", 2'd3, 60, n);
    end
    check_eq("relock_sat", relock_count, 255);
    check_eq("sat_timeout_sticky", lock_timeout, 1);

    // rst during STABLE
    force_relock = 1'b1;
    cyc();
    force_relock = 1'b0;
    run_until_state("rst_to_stable", 2'd2, 20, n);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_eq("midrst_state", state, 0);
    check_eq("midrst_pll_rst", pll_rst, 1);
    check_eq("midrst_ready", sys_ready, 0);
    check_eq("midrst_relock", relock_count, 0);
    check_eq("midrst_timeout", lock_timeout, 0);

    // random traffic
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 39) == 0) pll_locked = ~pll_locked;
      force_relock = ($urandom_range(0, 199) == 0);
      rst = ($urandom_range(0, 999) == 0);
      cyc();
    end
    rst = 1'b0;
    force_relock = 1'b0;
    cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
